// File: rtl/pe_feeder_if.sv
// -----------------------------------------------------------------------------
// pe_feeder_if
// Groups the job-control, filter/ifmap load ports and PE drive outputs of
// pe_feeder into one bundle.
//   master : the upstream side. It drives start, the load valids and the load
//            data, and it observes the readies, the PE operands and the
//            strobes.
//   slave  : the feeder itself.
// Signals:
//   start, start_keep_filt       job request and filter-reuse qualifier
//   filt_valid/ready/data        filter row load port
//   ifmap_valid/ready/data       ifmap row load port
//   pe_ifmap, pe_filter          PE operands
//   pe_en, pe_clr                PE accumulate enable / accumulator clear
//   psum_strobe, psum_idx        finished-window strobe and window number
//   busy, done                   job status
// -----------------------------------------------------------------------------
interface pe_feeder_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              start;
  logic              start_keep_filt;
  logic              filt_valid;
  logic              filt_ready;
  logic [DATA_W-1:0] filt_data;
  logic              ifmap_valid;
  logic              ifmap_ready;
  logic [DATA_W-1:0] ifmap_data;
  logic [DATA_W-1:0] pe_ifmap;
  logic [DATA_W-1:0] pe_filter;
  logic              pe_en;
  logic              pe_clr;
  logic              psum_strobe;
  logic [IDX_W-1:0]  psum_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, start_keep_filt,
    output filt_valid, filt_data, ifmap_valid, ifmap_data,
    input  filt_ready, ifmap_ready,
    input  pe_ifmap, pe_filter, pe_en, pe_clr,
    input  psum_strobe, psum_idx, busy, done
  );

  modport slave (
    input  start, start_keep_filt,
    input  filt_valid, filt_data, ifmap_valid, ifmap_data,
    output filt_ready, ifmap_ready,
    output pe_ifmap, pe_filter, pe_en, pe_clr,
    output psum_strobe, psum_idx, busy, done
  );
endinterface

// File: rtl/pe_feeder.sv
// -----------------------------------------------------------------------------
// pe_feeder
// Upstream sequencer for a single MAC processing element. It buffers one
// filter row (FILT_LEN taps) and one ifmap row (IFMAP_LEN samples) through
// valid/ready load ports. It then walks the IFMAP_LEN-FILT_LEN+1 sliding
// windows. For each window it clears the PE, issues FILT_LEN accumulate
// cycles, and strobes psum_strobe/psum_idx in the cycle where the PE output
// holds that window's result.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (state, counters, buffers, outputs)
//   bus  : pe_feeder_if.slave (job control, load ports, PE drive, status)
// Every output is a register loaded from the next-state decode, so nothing
// on the input side reaches an output combinationally.
// -----------------------------------------------------------------------------
module pe_feeder #(
  parameter int DATA_W    = 16,
  parameter int FILT_LEN  = 3,
  parameter int IFMAP_LEN = 8,
  parameter int IDX_W     = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1
) (
  input logic       clk,
  input logic       rst,
  pe_feeder_if.slave bus
);

  localparam int N_WIN  = IFMAP_LEN - FILT_LEN + 1;
  localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int ICNT_W = IDX_W;

  localparam logic [FCNT_W-1:0] F_LAST   = FCNT_W'(FILT_LEN - 1);
  localparam logic [ICNT_W-1:0] I_LAST   = ICNT_W'(IFMAP_LEN - 1);
  localparam logic [ICNT_W-1:0] WIN_LAST = ICNT_W'(N_WIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_F = 3'd1,
    ST_LOAD_I = 3'd2,
    ST_CLR    = 3'd3,
    ST_MAC    = 3'd4,
    ST_FINAL  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic [ICNT_W-1:0] win_q, win_d;
  logic [FCNT_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] fbuf_q [FILT_LEN];
  logic [DATA_W-1:0] fbuf_d [FILT_LEN];
  logic [DATA_W-1:0] ibuf_q [IFMAP_LEN];
  logic [DATA_W-1:0] ibuf_d [IFMAP_LEN];

  logic              filt_ready_q, filt_ready_d;
  logic              ifmap_ready_q, ifmap_ready_d;
  logic [DATA_W-1:0] pe_ifmap_q, pe_ifmap_d;
  logic [DATA_W-1:0] pe_filter_q, pe_filter_d;
  logic              pe_en_q, pe_en_d;
  logic              pe_clr_q, pe_clr_d;
  logic              psum_strobe_q, psum_strobe_d;
  logic [IDX_W-1:0]  psum_idx_q, psum_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ICNT_W-1:0] mac_idx_s;

  // Next-state logic: sequencing, load counters, window/tap counters, buffers.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    icnt_d  = icnt_q;
    win_d   = win_q;
    k_d     = k_q;
    fbuf_d  = fbuf_q;
    ibuf_d  = ibuf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          fcnt_d  = {FCNT_W{1'b0}};
          icnt_d  = {ICNT_W{1'b0}};
          state_d = bus.start_keep_filt ? ST_LOAD_I : ST_LOAD_F;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_F: begin
        // filt_ready_q is high throughout LOAD_F, so valid alone is a handshake.
        if (bus.filt_valid) begin
          fbuf_d[fcnt_q] = bus.filt_data;
          if (fcnt_q == F_LAST) begin
            fcnt_d  = {FCNT_W{1'b0}};
            state_d = ST_LOAD_I;
          end else begin
            fcnt_d = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_LOAD_F;
        end
      end
      ST_LOAD_I: begin
        if (bus.ifmap_valid) begin
          ibuf_d[icnt_q] = bus.ifmap_data;
          if (icnt_q == I_LAST) begin
            icnt_d  = {ICNT_W{1'b0}};
            win_d   = {ICNT_W{1'b0}};
            state_d = ST_CLR;
          end else begin
            icnt_d = icnt_q + {{(ICNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_LOAD_I;
        end
      end
      ST_CLR: begin
        k_d     = {FCNT_W{1'b0}};
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (k_q == F_LAST) begin
          k_d = {FCNT_W{1'b0}};
          if (win_q == WIN_LAST) begin
            state_d = ST_FINAL;
          end else begin
            win_d   = win_q + {{(ICNT_W-1){1'b0}}, 1'b1};
            state_d = ST_CLR;
          end
        end else begin
          k_d = k_q + {{(FCNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FINAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    filt_ready_d  = (state_d == ST_LOAD_F);
    ifmap_ready_d = (state_d == ST_LOAD_I);
    pe_en_d       = (state_d == ST_MAC);
    pe_clr_d      = (state_d == ST_CLR);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_FINAL);
    mac_idx_s     = win_d + ICNT_W'(k_d);
    if (state_d == ST_MAC) begin
      pe_ifmap_d  = ibuf_q[mac_idx_s];
      pe_filter_d = fbuf_q[k_d];
    end else begin
      pe_ifmap_d  = {DATA_W{1'b0}};
      pe_filter_d = {DATA_W{1'b0}};
    end
    // The previous window's strobe rides on the next window's CLR cycle,
    // because the PE accumulator still holds that result until the clear edge.
    if (state_d == ST_FINAL) begin
      psum_strobe_d = 1'b1;
      psum_idx_d    = WIN_LAST;
    end else if ((state_d == ST_CLR) && (win_d != {ICNT_W{1'b0}})) begin
      psum_strobe_d = 1'b1;
      psum_idx_d    = win_d - {{(ICNT_W-1){1'b0}}, 1'b1};
    end else begin
      psum_strobe_d = 1'b0;
      psum_idx_d    = {IDX_W{1'b0}};
    end
  end

  // State, counter, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fcnt_q        <= {FCNT_W{1'b0}};
      icnt_q        <= {ICNT_W{1'b0}};
      win_q         <= {ICNT_W{1'b0}};
      k_q           <= {FCNT_W{1'b0}};
      fbuf_q        <= '{default: {DATA_W{1'b0}}};
      ibuf_q        <= '{default: {DATA_W{1'b0}}};
      filt_ready_q  <= 1'b0;
      ifmap_ready_q <= 1'b0;
      pe_ifmap_q    <= {DATA_W{1'b0}};
      pe_filter_q   <= {DATA_W{1'b0}};
      pe_en_q       <= 1'b0;
      pe_clr_q      <= 1'b0;
      psum_strobe_q <= 1'b0;
      psum_idx_q    <= {IDX_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      icnt_q        <= icnt_d;
      win_q         <= win_d;
      k_q           <= k_d;
      fbuf_q        <= fbuf_d;
      ibuf_q        <= ibuf_d;
      filt_ready_q  <= filt_ready_d;
      ifmap_ready_q <= ifmap_ready_d;
      pe_ifmap_q    <= pe_ifmap_d;
      pe_filter_q   <= pe_filter_d;
      pe_en_q       <= pe_en_d;
      pe_clr_q      <= pe_clr_d;
      psum_strobe_q <= psum_strobe_d;
      psum_idx_q    <= psum_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.filt_ready  = filt_ready_q;
  assign bus.ifmap_ready = ifmap_ready_q;
  assign bus.pe_ifmap    = pe_ifmap_q;
  assign bus.pe_filter   = pe_filter_q;
  assign bus.pe_en       = pe_en_q;
  assign bus.pe_clr      = pe_clr_q;
  assign bus.psum_strobe = psum_strobe_q;
  assign bus.psum_idx    = psum_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pe_feeder.sv
// -----------------------------------------------------------------------------
// tb_pe_feeder
// Directed job sequence with randomized data and idle-bus noise. A small PE
// model accumulates whatever operands the feeder drives. The psum seen on
// each strobe is compared with the windowed dot product computed directly
// from the rows that were handed over.
// -----------------------------------------------------------------------------
module tb_pe_feeder;
  localparam int DW = 16;
  localparam int S  = 3;
  localparam int W  = 8;
  localparam int N  = W - S + 1;
  localparam int IW = 3;

  logic clk;
  logic rst;

  pe_feeder_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  pe_feeder #(.DATA_W(DW), .FILT_LEN(S), .IFMAP_LEN(W), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] filt_src  [S];
  logic [DW-1:0] ifmap_src [W];
  logic [DW-1:0] fbuf_m    [S];
  logic [DW-1:0] ibuf_m    [W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {22'd0, bus.busy, bus.filt_ready, bus.ifmap_ready, bus.pe_en, bus.pe_clr,
            bus.psum_strobe, bus.done, bus.psum_idx, bus.pe_ifmap, bus.pe_filter};
  endfunction

  // Window w of a valid 1-D convolution, each product and the sum kept mod 2^16.
  function automatic logic [15:0] exp_psum(input int w);
    longint sum = 0;
    for (int k = 0; k < S; k++) begin
      longint p = longint'(ibuf_m[w+k]) * longint'(fbuf_m[k]);
      sum = (sum + (p % 65536)) % 65536;
    end
    return 16'(sum);
  endfunction

  task automatic run_job(input bit keep, input bit bp, input bit poke, input int rst_win);
    int lf = 0, li = 0, bc = 0, ns = 0, nd = 0, last_sc = 0, fi = 0, ii = 0, macs = 0, cyc;
    bit did_rst = 1'b0;
    logic [15:0] acc = 16'd0, acc_n;
    logic [31:0] prod;
    logic [15:0] got[$];
    int exp_lf, exp_li;

    @(negedge clk);
    bus.start = 1'b1;
    bus.start_keep_filt = keep;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.start_keep_filt = 1'($urandom_range(0, 1));
      if (did_rst) begin
        chk("rst_outs", outs(), 64'd0);
        rst = 1'b0;
        break;
      end
      if (!bus.busy) break;
      bc++;
      if (bus.filt_ready) lf++;
      if (bus.ifmap_ready) li++;
      if (bus.psum_strobe) begin
        chk("idx", 64'(bus.psum_idx), 64'(ns));
        chk("done_on_last", 64'(bus.done), 64'(ns == N - 1));
        if (ns > 0) chk("strobe_gap", 64'(cyc - last_sc), 64'(S + 1));
        last_sc = cyc;
        got.push_back(acc);
        ns++;
      end
      if (bus.done) nd++;
      if (bus.pe_en) macs++;
      // PE model: registered accumulator, clear has priority over enable.
      prod = bus.pe_ifmap * bus.pe_filter;
      if (bus.pe_clr) acc_n = 16'd0;
      else if (bus.pe_en) acc_n = acc + prod[15:0];
      else acc_n = acc;
      // Upstream drivers: valids with optional 1,0,1,0 pattern, noise when not ready.
      if (bus.filt_ready) begin
        bus.filt_valid = !bp || ((lf - 1) % 2 == 0);
        bus.filt_data  = filt_src[fi % S];
      end else begin
        bus.filt_valid = 1'($urandom_range(0, 1));
        bus.filt_data  = 16'($urandom);
      end
      if (bus.ifmap_ready) begin
        bus.ifmap_valid = !bp || ((li - 1) % 2 == 0);
        bus.ifmap_data  = ifmap_src[ii % W];
      end else begin
        bus.ifmap_valid = 1'($urandom_range(0, 1));
        bus.ifmap_data  = 16'($urandom);
      end
      if (bus.filt_valid && bus.filt_ready) begin
        if (fi < S) fbuf_m[fi] = bus.filt_data;
        fi++;
      end
      if (bus.ifmap_valid && bus.ifmap_ready) begin
        if (ii < W) ibuf_m[ii] = bus.ifmap_data;
        ii++;
      end
      if (poke && ((bus.ifmap_ready && li == 3) || (bus.pe_en && macs == 4) || bus.done))
        bus.start = 1'b1;
      if (rst_win >= 0 && bus.pe_en && ns == rst_win) begin
        rst = 1'b1;
        did_rst = 1'b1;
        for (int k = 0; k < S; k++) fbuf_m[k] = 16'd0;
        for (int k = 0; k < W; k++) ibuf_m[k] = 16'd0;
      end
      acc = acc_n;
    end
    if (cyc >= 600) chk("timeout", 64'(bus.busy), 64'd0);
    bus.filt_valid  = 1'b0;
    bus.ifmap_valid = 1'b0;
    if (!did_rst) begin
      exp_lf = keep ? 0 : (bp ? 2 * S - 1 : S);
      exp_li = bp ? 2 * W - 1 : W;
      chk("strobes", 64'(ns), 64'(N));
      chk("done_cnt", 64'(nd), 64'd1);
      chk("load_f_cycles", 64'(lf), 64'(exp_lf));
      chk("load_i_cycles", 64'(li), 64'(exp_li));
      chk("busy_cycles", 64'(bc), 64'(exp_lf + exp_li + N * (S + 1) + 1));
      for (int w = 0; w < N && w < got.size(); w++)
        chk($sformatf("psum%0d", w), 64'(got[w]), 64'(exp_psum(w)));
      @(negedge clk);
      chk("idle_after", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic set_basic();
    for (int k = 0; k < S; k++) filt_src[k] = 16'(k + 1);
    for (int k = 0; k < W; k++) ifmap_src[k] = 16'(k + 1);
  endtask

  task automatic rand_rows();
    for (int k = 0; k < S; k++) filt_src[k] = 16'($urandom);
    for (int k = 0; k < W; k++) ifmap_src[k] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_keep_filt = 1'b0;
    bus.filt_valid = 1'b0;
    bus.filt_data = 16'd0;
    bus.ifmap_valid = 1'b0;
    bus.ifmap_data = 16'd0;
    for (int k = 0; k < S; k++) fbuf_m[k] = 16'd0;
    for (int k = 0; k < W; k++) ibuf_m[k] = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;

    // Filter reuse straight after reset: zeroed filter, every psum 0.
    rand_rows();
    run_job(1'b1, 1'b0, 1'b0, -1);
    // Basic row, then the same row under backpressure.
    set_basic();
    run_job(1'b0, 1'b0, 1'b0, -1);
    run_job(1'b0, 1'b1, 1'b0, -1);
    // Filter reuse with a constant ifmap.
    for (int k = 0; k < W; k++) ifmap_src[k] = 16'd2;
    run_job(1'b1, 1'b0, 1'b0, -1);
    // Product and sum wrap.
    rand_rows();
    filt_src[0] = 16'hFFFF;
    filt_src[1] = 16'h0001;
    filt_src[2] = 16'h0000;
    ifmap_src[0] = 16'h0002;
    run_job(1'b0, 1'b0, 1'b0, -1);
    // Start pulses during LOAD_I, MAC and FINAL are ignored.
    set_basic();
    run_job(1'b0, 1'b0, 1'b1, -1);
    // Random rows, random backpressure and filter reuse.
    for (int j = 0; j < 4; j++) begin
      rand_rows();
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end
    // Reset during the third window, then reuse of the cleared buffers.
    set_basic();
    run_job(1'b0, 1'b0, 1'b0, 2);
    rand_rows();
    run_job(1'b1, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
